// File: rtl/word_serializer_if.sv
// Word-in / lane-out channel bundle for the word serializer.
// slave: the serializer's view. master: the producer/consumer side (bench or neighbours).
interface word_serializer_if #(
  parameter int DATA_W = 32,
  parameter int LANE_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [LANE_W-1:0] lane_data;
  logic              lane_valid;
  logic              lane_ready;
  logic              lane_first;
  logic              lane_last;
  logic              busy;

  modport slave (
    input  in_data, in_valid, lane_ready,
    output in_ready, lane_data, lane_valid, lane_first, lane_last, busy
  );

  modport master (
    output in_data, in_valid, lane_ready,
    input  in_ready, lane_data, lane_valid, lane_first, lane_last, busy
  );
endinterface

// File: rtl/word_serializer.sv
// Word-to-lane serializer: takes a DATA_W word on a valid/ready handshake and
// emits it as DATA_W/LANE_W beats with first/last framing and full backpressure.
// Back-to-back words stream with no bubble: the next word loads on the last beat.
module word_serializer #(
  parameter int DATA_W    = 32,
  parameter int LANE_W    = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  word_serializer_if.slave  bus
);
  localparam int BEATS = DATA_W / LANE_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  // Reject geometries that cannot be split into at least two whole beats.
  if ((DATA_W % LANE_W) != 0 || BEATS < 2) begin : g_bad_geometry
    $error("word_serializer: DATA_W must be a multiple of LANE_W with at least 2 beats");
  end

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] sr_q, sr_d;

  logic              is_last;
  logic              beat_xfer;
  logic [DATA_W-1:0] sr_shifted;
  logic [LANE_W-1:0] out_slice;

  assign is_last    = (state_q == SEND) && (cnt_q == LAST_CNT);
  assign beat_xfer  = (state_q == SEND) && bus.lane_ready;
  // Shift toward whichever end feeds the lane; vacated bits fill with zero.
  assign sr_shifted = (MSB_FIRST != 0) ? (sr_q << LANE_W) : (sr_q >> LANE_W);
  assign out_slice  = (MSB_FIRST != 0) ? sr_q[DATA_W-1 -: LANE_W] : sr_q[LANE_W-1:0];

  // State register: FSM state, beat counter and shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
    end
  end

  // Next-state: load on accept, shift/count per transferred beat, reload on last beat.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sr_d    = bus.in_data;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (beat_xfer) begin
          if (is_last) begin
            cnt_d = '0;
            if (bus.in_valid) begin
              sr_d = bus.in_data;
            end else begin
              sr_d    = sr_shifted;
              state_d = IDLE;
            end
          end else begin
            sr_d  = sr_shifted;
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: lane framing from state/counter; in_ready held low while in reset.
  always_comb begin
    bus.lane_valid = (state_q == SEND);
    bus.lane_first = (state_q == SEND) && (cnt_q == '0);
    bus.lane_last  = is_last;
    bus.lane_data  = (state_q == SEND) ? out_slice : '0;
    bus.busy       = (state_q == SEND);
    bus.in_ready   = !rst && ((state_q == IDLE) || (bus.lane_ready && is_last));
  end
endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer: three instances cover MSB-first 32/8,
// LSB-first 32/8 and a 16/4 geometry.
module tb_word_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  word_serializer_if #(.DATA_W(32), .LANE_W(8)) a ();
  word_serializer_if #(.DATA_W(32), .LANE_W(8)) b ();
  word_serializer_if #(.DATA_W(16), .LANE_W(4)) c ();

  word_serializer #(.DATA_W(32), .LANE_W(8), .MSB_FIRST(1)) dut_a (.clk(clk), .rst(rst), .bus(a.slave));
  word_serializer #(.DATA_W(32), .LANE_W(8), .MSB_FIRST(0)) dut_b (.clk(clk), .rst(rst), .bus(b.slave));
  word_serializer #(.DATA_W(16), .LANE_W(4), .MSB_FIRST(1)) dut_c (.clk(clk), .rst(rst), .bus(c.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    a.in_data = '0; a.in_valid = 1'b0; a.lane_ready = 1'b1;
    b.in_data = '0; b.in_valid = 1'b0; b.lane_ready = 1'b1;
    c.in_data = '0; c.in_valid = 1'b0; c.lane_ready = 1'b1;
    #2;
    // Reset state: {valid,first,last,data}, busy, in_ready.
    chk("rst_lane_a", {a.lane_valid, a.lane_first, a.lane_last, a.lane_data}, 32'h0);
    chk("rst_busy_a", a.busy, 1'b0);
    chk("rst_rdy_a", a.in_ready, 1'b0);
    chk("rst_lane_c", {c.lane_valid, c.lane_first, c.lane_last, c.lane_data}, 32'h0);
    #10 rst = 1'b0;
    tick;
    chk("idle_rdy_a", a.in_ready, 1'b1);

    // 1: single word, no backpressure.
    a.in_data = 32'h0001_023F; a.in_valid = 1'b1;
    tick; a.in_valid = 1'b0;
    chk("t1_b0", {a.lane_valid, a.lane_first, a.lane_last, a.lane_data}, {3'b110, 8'h00});
    chk("t1_busy", a.busy, 1'b1);
    tick; chk("t1_b1", {a.lane_valid, a.lane_first, a.lane_last, a.lane_data}, {3'b100, 8'h01});
    tick; chk("t1_b2", {a.lane_valid, a.lane_first, a.lane_last, a.lane_data}, {3'b100, 8'h02});
    chk("t1_rdy_mid", a.in_ready, 1'b0);
    tick; chk("t1_b3", {a.lane_valid, a.lane_first, a.lane_last, a.lane_data}, {3'b101, 8'h3F});
    chk("t1_rdy_last", a.in_ready, 1'b1);
    tick; chk("t1_idle", {a.lane_valid, a.busy}, 2'b00);

    // 2: back-to-back words, in_data changed mid-word must not disturb the word in flight.
    a.in_data = 32'hAABB_CCDD; a.in_valid = 1'b1;
    tick;
    chk("t2_aa", {a.lane_valid, a.lane_first, a.lane_last, a.lane_data}, {3'b110, 8'hAA});
    chk("t2_rdy_aa", a.in_ready, 1'b0);
    a.in_data = 32'h1122_3344;
    tick; chk("t2_bb", {a.lane_valid, a.lane_first, a.lane_last, a.lane_data}, {3'b100, 8'hBB});
    chk("t2_rdy_bb", a.in_ready, 1'b0);
    tick; chk("t2_cc", {a.lane_valid, a.lane_first, a.lane_last, a.lane_data}, {3'b100, 8'hCC});
    tick; chk("t2_dd", {a.lane_valid, a.lane_first, a.lane_last, a.lane_data}, {3'b101, 8'hDD});
    chk("t2_rdy_dd", a.in_ready, 1'b1);
    tick; a.in_valid = 1'b0;
    chk("t2_11", {a.lane_valid, a.lane_first, a.lane_last, a.lane_data}, {3'b110, 8'h11});
    tick; chk("t2_22", {a.lane_valid, a.lane_first, a.lane_last, a.lane_data}, {3'b100, 8'h22});
    tick; chk("t2_33", {a.lane_valid, a.lane_first, a.lane_last, a.lane_data}, {3'b100, 8'h33});
    tick; chk("t2_44", {a.lane_valid, a.lane_first, a.lane_last, a.lane_data}, {3'b101, 8'h44});
    tick; chk("t2_idle", {a.lane_valid, a.busy}, 2'b00);

    // 3: backpressure while BB is shown.
    a.in_data = 32'hAABB_CCDD; a.in_valid = 1'b1;
    tick; a.in_valid = 1'b0;
    chk("t3_aa", {a.lane_valid, a.lane_first, a.lane_last, a.lane_data}, {3'b110, 8'hAA});
    tick; a.lane_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t3_hold%0d", i), {a.lane_valid, a.lane_first, a.lane_last, a.lane_data}, {3'b100, 8'hBB});
      chk($sformatf("t3_busy%0d", i), {a.busy, a.in_ready}, 2'b10);
      tick;
    end
    a.lane_ready = 1'b1;
    chk("t3_bb_go", {a.lane_valid, a.lane_first, a.lane_last, a.lane_data}, {3'b100, 8'hBB});
    tick; chk("t3_cc", {a.lane_valid, a.lane_first, a.lane_last, a.lane_data}, {3'b100, 8'hCC});
    tick; chk("t3_dd", {a.lane_valid, a.lane_first, a.lane_last, a.lane_data}, {3'b101, 8'hDD});
    tick; chk("t3_idle", {a.lane_valid, a.busy}, 2'b00);

    // 5: reset mid-word, then a clean word.
    a.in_data = 32'h0001_023F; a.in_valid = 1'b1;
    tick; a.in_valid = 1'b0;
    tick; chk("t5_b1", {a.lane_valid, a.lane_first, a.lane_last, a.lane_data}, {3'b100, 8'h01});
    rst = 1'b1;
    #1;
    chk("t5_rst_lane", {a.lane_valid, a.busy, a.in_ready}, 3'b000);
    #2 rst = 1'b0;
    tick; chk("t5_idle_rdy", {a.lane_valid, a.in_ready}, 2'b01);
    a.in_data = 32'h1234_5678; a.in_valid = 1'b1;
    tick; a.in_valid = 1'b0;
    chk("t5_12", {a.lane_valid, a.lane_first, a.lane_last, a.lane_data}, {3'b110, 8'h12});
    tick; chk("t5_34", {a.lane_valid, a.lane_first, a.lane_last, a.lane_data}, {3'b100, 8'h34});
    tick; chk("t5_56", {a.lane_valid, a.lane_first, a.lane_last, a.lane_data}, {3'b100, 8'h56});
    tick; chk("t5_78", {a.lane_valid, a.lane_first, a.lane_last, a.lane_data}, {3'b101, 8'h78});

    // 4: LSB-first order.
    b.in_data = 32'h0001_023F; b.in_valid = 1'b1;
    tick; b.in_valid = 1'b0;
    chk("t4_3f", {b.lane_valid, b.lane_first, b.lane_last, b.lane_data}, {3'b110, 8'h3F});
    tick; chk("t4_02", {b.lane_valid, b.lane_first, b.lane_last, b.lane_data}, {3'b100, 8'h02});
    tick; chk("t4_01", {b.lane_valid, b.lane_first, b.lane_last, b.lane_data}, {3'b100, 8'h01});
    tick; chk("t4_00", {b.lane_valid, b.lane_first, b.lane_last, b.lane_data}, {3'b101, 8'h00});
    tick; chk("t4_idle", {b.lane_valid, b.busy}, 2'b00);

    // 6: 16-bit word on a 4-bit lane.
    c.in_data = 16'hBEEF; c.in_valid = 1'b1;
    tick; c.in_valid = 1'b0;
    chk("t6_b", {c.lane_valid, c.lane_first, c.lane_last, c.lane_data}, {3'b110, 4'hB});
    tick; chk("t6_e0", {c.lane_valid, c.lane_first, c.lane_last, c.lane_data}, {3'b100, 4'hE});
    tick; chk("t6_e1", {c.lane_valid, c.lane_first, c.lane_last, c.lane_data}, {3'b100, 4'hE});
    tick; chk("t6_f", {c.lane_valid, c.lane_first, c.lane_last, c.lane_data}, {3'b101, 4'hF});
    tick; chk("t6_idle", {c.lane_valid, c.busy}, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
